// File: rtl/tree_result_collector_pkg.sv
// Shared types and leaf-node field constants for the tree result collector.
// The entry struct is sized by the DEF_/LEAF_ constants, so top-level widths must match them.
package tree_result_collector_pkg;

    localparam int DEF_PACKET_WIDTH = 104;
    localparam int DEF_NODE_WIDTH   = 40;
    localparam int DEF_FIFO_DEPTH   = 16;
    localparam int DEF_DROP_W       = 16;

    localparam int LEAF_RULE_MSB    = 14;
    localparam int LEAF_RULE_W      = 14;
    localparam int LEAF_FLAG_BIT    = 0;

    typedef enum logic {
        LANE_1 = 1'b0,
        LANE_2 = 1'b1
    } lane_t;

    typedef struct packed {
        logic [DEF_PACKET_WIDTH-1:0] packet;
        logic                        hit;
        logic [LEAF_RULE_W-1:0]      rule_id;
    } entry_t;

endpackage

// File: rtl/tree_result_collector_if.sv
// Result stream toward the action stage: valid/ready handshake plus the decoded result fields.
interface tree_result_collector_if #(
    parameter int PACKET_WIDTH = 104,
    parameter int RULE_W       = 14
);
    logic                    result_valid;
    logic                    result_ready;
    logic [PACKET_WIDTH-1:0] result_packet;
    logic [RULE_W-1:0]       result_rule_id;
    logic                    result_hit;
    logic                    result_lane;

    modport master (
        output result_valid, result_packet, result_rule_id, result_hit, result_lane,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_packet, result_rule_id, result_hit, result_lane,
        output result_ready
    );
endinterface

// File: rtl/tree_result_collector_lane_fifo.sv
// First-word-fall-through lane FIFO with an occupancy counter; a push into a full FIFO
// is accepted only when the same cycle also pops.
module collector_lane_fifo
    import tree_result_collector_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/tree_result_collector.sv
// Final tree-lookup stage: decodes both lanes into rule IDs, buffers each lane and merges
// them round-robin into a single registered valid/ready result stream.
module tree_result_collector
    import tree_result_collector_pkg::*;
#(
    parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
    parameter int NODE_WIDTH   = DEF_NODE_WIDTH,
    parameter int RULE_MSB     = LEAF_RULE_MSB,
    parameter int RULE_W       = LEAF_RULE_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int DROP_W       = DEF_DROP_W
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic                    data_valid_in1,
    input  logic                    data_valid_in2,
    input  logic [NODE_WIDTH-1:0]   node_in1,
    input  logic [NODE_WIDTH-1:0]   node_in2,
    input  logic                    matched_in1,
    input  logic                    matched_in2,
    tree_result_collector_if.master res,
    output logic [DROP_W-1:0]       drop_cnt1,
    output logic [DROP_W-1:0]       drop_cnt2
);
    entry_t            in1, in2, dout1, dout2;
    logic              full1, full2, empty1, empty2;
    logic              pop1, pop2, load, have_src;
    lane_t             grant;
    lane_t             last_granted_q, last_granted_d;
    lane_t             lane_q, lane_d;
    logic              valid_q, valid_d;
    entry_t            out_q, out_d;
    logic [DROP_W-1:0] drop1_q, drop1_d, drop2_q, drop2_d;
    logic              unused_node_bits;

    // The leaf flag and the bits outside the rule field duplicate matched_in or carry nothing here.
    assign unused_node_bits = ^{node_in1, node_in2, node_in1[LEAF_FLAG_BIT], node_in2[LEAF_FLAG_BIT]};

    always_comb begin
        in1.packet  = packet_in1;
        in1.hit     = matched_in1;
        in1.rule_id = matched_in1 ? node_in1[RULE_MSB -: RULE_W] : '0;
        in2.packet  = packet_in2;
        in2.hit     = matched_in2;
        in2.rule_id = matched_in2 ? node_in2[RULE_MSB -: RULE_W] : '0;
    end

    collector_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(RSTn), .push(data_valid_in1), .pop(pop1),
        .din(in1), .dout(dout1), .full(full1), .empty(empty1)
    );

    collector_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo2 (
        .clk(clk), .rst_n(RSTn), .push(data_valid_in2), .pop(pop2),
        .din(in2), .dout(dout2), .full(full2), .empty(empty2)
    );

    // Round-robin only matters on a tie; otherwise whichever lane holds data is served.
    always_comb begin
        load     = !valid_q || res.result_ready;
        have_src = !empty1 || !empty2;
        grant    = LANE_1;
        if (!empty1 && !empty2) begin
            grant = (last_granted_q == LANE_1) ? LANE_2 : LANE_1;
        end else if (empty1) begin
            grant = LANE_2;
        end
        pop1 = load && !empty1 && (grant == LANE_1);
        pop2 = load && !empty2 && (grant == LANE_2);

        last_granted_d = last_granted_q;
        valid_d        = valid_q;
        out_d          = out_q;
        lane_d         = lane_q;
        if (load) begin
            valid_d = have_src;
            if (have_src) begin
                out_d          = (grant == LANE_1) ? dout1 : dout2;
                lane_d         = grant;
                last_granted_d = grant;
            end
        end

        drop1_d = drop1_q;
        drop2_d = drop2_q;
        if (data_valid_in1 && full1 && !pop1 && (drop1_q != '1)) begin
            drop1_d = drop1_q + DROP_W'(1);
        end
        if (data_valid_in2 && full2 && !pop2 && (drop2_q != '1)) begin
            drop2_d = drop2_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            last_granted_q <= LANE_2;
            valid_q        <= 1'b0;
            out_q          <= '0;
            lane_q         <= LANE_1;
            drop1_q        <= '0;
            drop2_q        <= '0;
        end else begin
            last_granted_q <= last_granted_d;
            valid_q        <= valid_d;
            out_q          <= out_d;
            lane_q         <= lane_d;
            drop1_q        <= drop1_d;
            drop2_q        <= drop2_d;
        end
    end

    assign res.result_valid   = valid_q;
    assign res.result_packet  = out_q.packet;
    assign res.result_rule_id = out_q.rule_id;
    assign res.result_hit     = out_q.hit;
    assign res.result_lane    = lane_q;
    assign drop_cnt1          = drop1_q;
    assign drop_cnt2          = drop2_q;

endmodule

// File: tb/tb_tree_result_collector.sv
// Self-checking bench: queue-based reference model of the collector, a per-cycle compare
// process, directed scenarios with literal expectations, then randomized traffic.
module tb_tree_result_collector;
    import tree_result_collector_pkg::*;

    localparam int PW    = 104;
    localparam int NW    = 40;
    localparam int DEPTH = 16;
    localparam int DW    = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [PW-1:0] packet_in1 = '0, packet_in2 = '0;
    logic          dv1 = 1'b0, dv2 = 1'b0;
    logic [NW-1:0] node1 = '0, node2 = '0;
    logic          m1 = 1'b0, m2 = 1'b0;
    logic [DW-1:0] drop_cnt1, drop_cnt2;

    int checks = 0;
    int errors = 0;

    tree_result_collector_if #(.PACKET_WIDTH(PW), .RULE_W(14)) res_if ();

    tree_result_collector dut (
        .clk(clk), .RSTn(rst_n),
        .packet_in1(packet_in1), .packet_in2(packet_in2),
        .data_valid_in1(dv1), .data_valid_in2(dv2),
        .node_in1(node1), .node_in2(node2),
        .matched_in1(m1), .matched_in2(m2),
        .res(res_if),
        .drop_cnt1(drop_cnt1), .drop_cnt2(drop_cnt2)
    );

    always #5 clk = ~clk;

    // Reference model state: plain queues per lane, a result slot and the last served lane.
    entry_t      mq1[$];
    entry_t      mq2[$];
    logic        m_valid = 1'b0;
    entry_t      m_out   = '0;
    logic        m_lane  = 1'b0;
    int          m_last  = 2;
    int unsigned m_drop1 = 0;
    int unsigned m_drop2 = 0;

    function automatic entry_t decode(input logic [PW-1:0] p, input logic hit, input logic [NW-1:0] node);
        entry_t e;
        e.packet  = p;
        e.hit     = hit;
        e.rule_id = hit ? 14'((node >> 1) & 40'h3FFF) : 14'd0;
        return e;
    endfunction

    function automatic logic [PW-1:0] rand_packet();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  n1, n2;
        bit  load, pop1, pop2;
        n1   = mq1.size();
        n2   = mq2.size();
        load = !m_valid || res_if.result_ready;
        pop1 = 1'b0;
        pop2 = 1'b0;
        if (load) begin
            if (n1 > 0 && n2 > 0) begin
                if (m_last == 1) pop2 = 1'b1; else pop1 = 1'b1;
            end else if (n1 > 0) pop1 = 1'b1;
            else if (n2 > 0) pop2 = 1'b1;
            if (pop1) begin
                m_out = mq1.pop_front(); m_lane = 1'b0; m_last = 1; m_valid = 1'b1;
            end else if (pop2) begin
                m_out = mq2.pop_front(); m_lane = 1'b1; m_last = 2; m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (dv1) begin
            if (n1 < DEPTH || pop1) mq1.push_back(decode(packet_in1, m1, node1));
            else if (m_drop1 < 65535) m_drop1++;
        end
        if (dv2) begin
            if (n2 < DEPTH || pop2) mq2.push_back(decode(packet_in2, m2, node2));
            else if (m_drop2 < 65535) m_drop2++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq1.delete(); mq2.delete();
            m_valid = 1'b0; m_out = '0; m_lane = 1'b0; m_last = 2;
            m_drop1 = 0; m_drop2 = 0;
        end else begin
            model_step();
        end
    end

    task automatic check_output();
        check("valid", res_if.result_valid, m_valid);
        check("packet", res_if.result_packet, m_out.packet);
        check("rule_id", res_if.result_rule_id, m_out.rule_id);
        check("hit", res_if.result_hit, m_out.hit);
        check("lane", res_if.result_lane, m_lane);
        check("drop_cnt1", drop_cnt1, m_drop1);
        check("drop_cnt2", drop_cnt2, m_drop2);
    endtask

    initial forever begin
        @(negedge clk);
        check_output();
    end

    task automatic apply_stimulus(input bit v1, input logic [PW-1:0] p1, input logic h1, input logic [NW-1:0] n1,
                                  input bit v2, input logic [PW-1:0] p2, input logic h2, input logic [NW-1:0] n2);
        @(negedge clk);
        dv1 = v1; packet_in1 = p1; m1 = h1; node1 = n1;
        dv2 = v2; packet_in2 = p2; m2 = h2; node2 = n2;
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic lane1_only(input logic [PW-1:0] p);
        apply_stimulus(1'b1, p, 1'b1, NW'($urandom()), 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [PW-1:0] pkt_a, pkt_b;
        int            lanes[$];
        int            drained;
        int            ready_pct;

        res_if.result_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_valid", res_if.result_valid, 0);
        check("rst_drop1", drop_cnt1, 0);

        // Single hit on lane 1: two-cycle latency, rule field node[14:1].
        pkt_a = 104'hDEAD_BEEF_0123_4567_89AB_CDEF_01;
        apply_stimulus(1'b1, pkt_a, 1'b1, 40'hF0_0000_0000 | (40'h1A5 << 1) | 40'h1,
                       1'b0, '0, 1'b0, '0);
        idle(1);
        check("hit_latency", res_if.result_valid, 0);
        idle(1);
        check("hit_valid", res_if.result_valid, 1);
        check("hit_rule", res_if.result_rule_id, 14'h1A5);
        check("hit_flag", res_if.result_hit, 1);
        check("hit_lane", res_if.result_lane, 0);
        check("hit_packet", res_if.result_packet, pkt_a);
        check("model_hit_rule", m_out.rule_id, 14'h1A5);

        // Miss on lane 2: rule ID forced to zero.
        pkt_b = 104'h0000_1111_2222_3333_4444_5555_66;
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, pkt_b, 1'b0, 40'h3FF << 1);
        idle(2);
        check("miss_valid", res_if.result_valid, 1);
        check("miss_rule", res_if.result_rule_id, 0);
        check("miss_hit", res_if.result_hit, 0);
        check("miss_lane", res_if.result_lane, 1);
        check("model_miss_lane", m_lane, 1);

        // Both lanes busy for 4 cycles: results alternate lane 1 / lane 2.
        for (int i = 0; i < 14; i++) begin
            if (i < 4) apply_stimulus(1'b1, rand_packet(), 1'b1, NW'($urandom()),
                                      1'b1, rand_packet(), 1'b0, NW'($urandom()));
            else idle(1);
            if (res_if.result_valid) lanes.push_back(int'(res_if.result_lane));
        end
        check("tie_count", lanes.size(), 8);
        for (int k = 0; k < lanes.size(); k++) check("tie_lane", lanes[k], k % 2);

        // Overflow: 20 entries with consumer stalled -> 16 buffered, 1 registered, 3 dropped.
        res_if.result_ready = 1'b0;
        for (int i = 0; i < 20; i++) lane1_only(rand_packet());
        idle(1);
        check("drop_after_burst", drop_cnt1, 3);
        check("model_drop_after_burst", m_drop1, 3);
        // Full lane popped while a new entry arrives: accepted, no drop.
        lane1_only(rand_packet());
        res_if.result_ready = 1'b1;
        drained = 0;
        if (res_if.result_valid) drained++;
        for (int i = 0; i < 25; i++) begin
            idle(1);
            if (res_if.result_valid) drained++;
        end
        check("drain_count", drained, 18);
        check("drop_after_drain", drop_cnt1, 3);

        // Asynchronous reset mid-cycle with entries buffered and a result pending.
        res_if.result_ready = 1'b0;
        for (int i = 0; i < 6; i++) lane1_only(rand_packet());
        idle(1);
        check("pre_rst_valid", res_if.result_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", res_if.result_valid, 0);
        check("rst_mid_packet", res_if.result_packet, 0);
        check("rst_mid_rule", res_if.result_rule_id, 0);
        check("rst_mid_hit", res_if.result_hit, 0);
        check("rst_mid_lane", res_if.result_lane, 0);
        check("rst_mid_drop1", drop_cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_if.result_ready = 1'b1;
        idle(4);
        check("post_rst_idle", res_if.result_valid, 0);

        // Randomized traffic with phases of varying consumer readiness.
        ready_pct = 10;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ready_pct = int'($urandom_range(0, 10));
            apply_stimulus($urandom_range(0, 1) == 1, rand_packet(), 1'($urandom()), NW'($urandom()),
                           $urandom_range(0, 1) == 1, rand_packet(), 1'($urandom()), NW'($urandom()));
            res_if.result_ready = ($urandom_range(0, 9) < ready_pct);
        end
        res_if.result_ready = 1'b1;
        idle(40);
        check("final_drained", res_if.result_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
